// File: rtl/calc2_port_agent.sv
// ---------------------------------------------------------------------------
// calc2_port_agent
//
// Request/response agent for one calc2 port. Instantiate one per
// reqN/out_respN link.
//
// Upstream requests {cmd, op1, op2, id} are buffered in a small FIFO. Each
// buffered request gets the lowest free 2-bit calc2 tag and is sent over the
// two-cycle command link. The first cycle carries cmd, op1 and the tag. The
// second cycle carries op2 with cmd and tag set to zero.
//
// Downstream responses are matched by tag against the set of tags that are
// awaiting a result. Each matched result is queued in arrival order together
// with the caller id of the originating request. A tag stays allocated until
// its result is popped from the response queue. At most four results can
// therefore ever be queued, so the 4-deep queue cannot overflow.
//
// Ports
//   c_clk, reset                     clock, asynchronous active-high reset
//   req_valid/req_ready              upstream request handshake
//   req_cmd/req_op1/req_op2/req_id   request payload
//   cmd_out/data_out/tag_out         registered command link to calc2
//   resp_in/rdata_in/rtag_in         response link from calc2
//   rsp_valid/rsp_ready              result handshake towards the consumer
//   rsp_code/rsp_data/rsp_id/rsp_tag result payload taken from the queue head
//   outstanding                      tags issued or holding an unpopped result
//   busy                             FIFO non-empty or any tag allocated
//   err_spurious                     sticky: unexpected response seen
//   err_timeout                      sticky: some tag waited TIMEOUT cycles
// ---------------------------------------------------------------------------
module calc2_port_agent #(
    parameter int REQ_DEPTH = 4,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_cmd,
    input  logic [DATA_W-1:0] req_op1,
    input  logic [DATA_W-1:0] req_op2,
    input  logic [ID_W-1:0]   req_id,
    output logic [3:0]        cmd_out,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        tag_out,
    input  logic [1:0]        resp_in,
    input  logic [DATA_W-1:0] rdata_in,
    input  logic [1:0]        rtag_in,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_code,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ID_W-1:0]   rsp_id,
    output logic [1:0]        rsp_tag,
    output logic [2:0]        outstanding,
    output logic              busy,
    output logic              err_spurious,
    output logic              err_timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OP1  = 2'd1;
    localparam logic [1:0] ST_OP2  = 2'd2;

    localparam int AW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);

    // Timeout counters saturate at the limit, so they never wrap and re-arm.
    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (v == TO_LIMIT) ? v : v + TW'(1);
    endfunction

    // ---------------------------------------------------------------- request FIFO
    logic [3:0]        fq_cmd [REQ_DEPTH];
    logic [DATA_W-1:0] fq_op1 [REQ_DEPTH];
    logic [DATA_W-1:0] fq_op2 [REQ_DEPTH];
    logic [ID_W-1:0]   fq_id  [REQ_DEPTH];
    logic [AW-1:0]     fq_wr;
    logic [AW-1:0]     fq_rd;
    logic [CW-1:0]     fq_cnt;
    logic              fq_push;
    logic              fq_pop;
    logic              fq_empty;

    assign req_ready = (fq_cnt != CW'(REQ_DEPTH));
    assign fq_empty  = (fq_cnt == '0);
    assign fq_push   = req_valid && req_ready;

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            fq_wr  <= '0;
            fq_rd  <= '0;
            fq_cnt <= '0;
        end else begin
            if (fq_push) fq_wr <= fq_wr + AW'(1);
            if (fq_pop)  fq_rd <= fq_rd + AW'(1);
            if (fq_push && !fq_pop)      fq_cnt <= fq_cnt + CW'(1);
            else if (fq_pop && !fq_push) fq_cnt <= fq_cnt - CW'(1);
        end
    end

    always_ff @(posedge c_clk) begin
        if (fq_push) begin
            fq_cmd[fq_wr] <= req_cmd;
            fq_op1[fq_wr] <= req_op1;
            fq_op2[fq_wr] <= req_op2;
            fq_id[fq_wr]  <= req_id;
        end
    end

    // ---------------------------------------------------------------- tag allocation
    logic [3:0]      tag_busy;   // allocated: issued, or result still queued
    logic [3:0]      tag_await;  // issued and no response captured yet
    logic [TW-1:0]   to_cnt [4];
    logic [3:0]      to_hit;
    logic [ID_W-1:0] id_mem [4];
    logic [1:0]      free_tag;
    logic            tag_avail;

    // Lowest free tag. tag_busy is registered, so a tag freed by a pop is
    // only seen as free from the edge after that pop.
    always_comb begin
        free_tag  = 2'd0;
        tag_avail = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!tag_busy[i]) begin
                free_tag  = 2'(i);
                tag_avail = 1'b1;
            end
        end
    end

    always_comb begin
        outstanding = 3'd0;
        for (int i = 0; i < 4; i++) begin
            outstanding = outstanding + {2'b00, tag_busy[i]};
        end
    end

    assign busy = !fq_empty || (tag_busy != 4'd0);

    // ---------------------------------------------------------------- issue FSM
    logic [1:0]        state;
    logic [DATA_W-1:0] op2_hold;
    logic              issue;

    // A new op may start in any cycle except the OP1 cycle, because OP2 must
    // follow OP1 on the link.
    assign issue  = !fq_empty && tag_avail && (state != ST_OP1);
    assign fq_pop = issue;

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cmd_out  <= 4'd0;
            data_out <= '0;
            tag_out  <= 2'd0;
        end else if (issue) begin
            state    <= ST_OP1;
            cmd_out  <= fq_cmd[fq_rd];
            data_out <= fq_op1[fq_rd];
            tag_out  <= free_tag;
        end else if (state == ST_OP1) begin
            state    <= ST_OP2;
            cmd_out  <= 4'd0;
            data_out <= op2_hold;
            tag_out  <= 2'd0;
        end else begin
            state    <= ST_IDLE;
            cmd_out  <= 4'd0;
            data_out <= '0;
            tag_out  <= 2'd0;
        end
    end

    always_ff @(posedge c_clk) begin
        if (issue) begin
            op2_hold         <= fq_op2[fq_rd];
            id_mem[free_tag] <= fq_id[fq_rd];
        end
    end

    // ---------------------------------------------------------------- response capture
    logic [1:0]        rq_code [4];
    logic [DATA_W-1:0] rq_data [4];
    logic [ID_W-1:0]   rq_id   [4];
    logic [1:0]        rq_tag  [4];
    logic [1:0]        rq_wr;
    logic [1:0]        rq_rd;
    logic [2:0]        rq_cnt;
    logic              resp_ok;
    logic              resp_hit;
    logic              resp_bad;
    logic              rq_pop;

    assign resp_ok  = (resp_in == 2'd1) || (resp_in == 2'd2);
    assign resp_hit = resp_ok && tag_await[rtag_in];
    assign resp_bad = (resp_in == 2'd3) || (resp_ok && !tag_await[rtag_in]);

    assign rsp_valid = (rq_cnt != 3'd0);
    assign rq_pop    = rsp_valid && rsp_ready;

    // Queue storage is not reset, so the payload is masked while the queue is empty.
    assign rsp_code = rsp_valid ? rq_code[rq_rd] : 2'd0;
    assign rsp_data = rsp_valid ? rq_data[rq_rd] : '0;
    assign rsp_id   = rsp_valid ? rq_id[rq_rd]   : '0;
    assign rsp_tag  = rsp_valid ? rq_tag[rq_rd]  : 2'd0;

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            rq_wr  <= 2'd0;
            rq_rd  <= 2'd0;
            rq_cnt <= 3'd0;
        end else begin
            if (resp_hit) rq_wr <= rq_wr + 2'd1;
            if (rq_pop)   rq_rd <= rq_rd + 2'd1;
            if (resp_hit && !rq_pop)      rq_cnt <= rq_cnt + 3'd1;
            else if (rq_pop && !resp_hit) rq_cnt <= rq_cnt - 3'd1;
        end
    end

    always_ff @(posedge c_clk) begin
        if (resp_hit) begin
            rq_code[rq_wr] <= resp_in;
            rq_data[rq_wr] <= rdata_in;
            rq_id[rq_wr]   <= id_mem[rtag_in];
            rq_tag[rq_wr]  <= rtag_in;
        end
    end

    // ---------------------------------------------------------------- tag state and errors
    // A counter that is about to reach the limit in this cycle flags a timeout,
    // unless that tag's response is being captured in the same cycle.
    always_comb begin
        to_hit = 4'd0;
        if (TIMEOUT != 0) begin
            for (int i = 0; i < 4; i++) begin
                to_hit[i] = tag_await[i] && !(resp_hit && (rtag_in == 2'(i)))
                            && (sat_inc(to_cnt[i]) == TO_LIMIT);
            end
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            tag_busy     <= 4'd0;
            tag_await    <= 4'd0;
            err_spurious <= 1'b0;
            err_timeout  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                to_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (issue && (free_tag == 2'(i))) begin
                    tag_busy[i]  <= 1'b1;
                    tag_await[i] <= 1'b1;
                    to_cnt[i]    <= '0;
                end else begin
                    if (rq_pop && (rq_tag[rq_rd] == 2'(i))) begin
                        tag_busy[i] <= 1'b0;
                    end
                    if (resp_hit && (rtag_in == 2'(i))) begin
                        tag_await[i] <= 1'b0;
                        to_cnt[i]    <= '0;
                    end else if (tag_await[i] && (TIMEOUT != 0)) begin
                        to_cnt[i] <= sat_inc(to_cnt[i]);
                    end
                end
            end
            if (to_hit != 4'd0) err_timeout  <= 1'b1;
            if (resp_bad)       err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_calc2_port_agent.sv
// ---------------------------------------------------------------------------
// tb_calc2_port_agent
//
// Directed bench for calc2_port_agent. The bench acts as the calc2 model by
// hand-driving resp_in/rdata_in/rtag_in. Every expected value below is worked
// out by hand from the agent's behaviour.
// ---------------------------------------------------------------------------
module tb_calc2_port_agent;

    logic        c_clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic [3:0]  req_id;
    logic [3:0]  cmd_out;
    logic [31:0] data_out;
    logic [1:0]  tag_out;
    logic [1:0]  resp_in;
    logic [31:0] rdata_in;
    logic [1:0]  rtag_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_code;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_id;
    logic [1:0]  rsp_tag;
    logic [2:0]  outstanding;
    logic        busy;
    logic        err_spurious;
    logic        err_timeout;

    calc2_port_agent #(
        .REQ_DEPTH(4),
        .DATA_W   (32),
        .ID_W     (4),
        .TIMEOUT  (16)
    ) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_op1     (req_op1),
        .req_op2     (req_op2),
        .req_id      (req_id),
        .cmd_out     (cmd_out),
        .data_out    (data_out),
        .tag_out     (tag_out),
        .resp_in     (resp_in),
        .rdata_in    (rdata_in),
        .rtag_in     (rtag_in),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_code    (rsp_code),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .rsp_tag     (rsp_tag),
        .outstanding (outstanding),
        .busy        (busy),
        .err_spurious(err_spurious),
        .err_timeout (err_timeout)
    );

    always #5 c_clk = ~c_clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [1:0]  iss_tag  [8];
    logic [31:0] iss_data [8];
    int          n_iss;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    // Records every OP1 cycle seen on the link.
    task automatic tick_rec();
        tick();
        if (cmd_out != 4'd0 && n_iss < 8) begin
            iss_tag[n_iss]  = tag_out;
            iss_data[n_iss] = data_out;
            n_iss++;
        end
    endtask

    task automatic clear_inputs();
        req_valid = 1'b0;
        req_cmd   = 4'd0;
        req_op1   = 32'd0;
        req_op2   = 32'd0;
        req_id    = 4'd0;
        resp_in   = 2'd0;
        rdata_in  = 32'd0;
        rtag_in   = 2'd0;
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_iss = 0;
    endtask

    task automatic push(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] id);
        req_valid = 1'b1;
        req_cmd   = c;
        req_op1   = a;
        req_op2   = b;
        req_id    = id;
        tick_rec();
        req_valid = 1'b0;
    endtask

    task automatic respond(input logic [1:0] code, input logic [31:0] d, input logic [1:0] t);
        resp_in  = code;
        rdata_in = d;
        rtag_in  = t;
        tick_rec();
        resp_in  = 2'd0;
        rdata_in = 32'd0;
        rtag_in  = 2'd0;
    endtask

    task automatic pop();
        rsp_ready = 1'b1;
        tick_rec();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] order [4];
        order[0] = 2'd3;
        order[1] = 2'd1;
        order[2] = 2'd0;
        order[3] = 2'd2;
        n_iss = 0;

        // Reset state
        reset = 1'b1;
        clear_inputs();
        #1;
        chk("rst_cmd_out",   32'(cmd_out), 0);
        chk("rst_data_out",  data_out, 0);
        chk("rst_tag_out",   32'(tag_out), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_outstand",  32'(outstanding), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_err_sp",    32'(err_spurious), 0);
        chk("rst_err_to",    32'(err_timeout), 0);
        tick();
        reset = 1'b0;
        tick();

        // 1: single add, link timing and result return
        push(4'd1, 32'd5, 32'd7, 4'd3);
        chk("t1_idle_cmd", 32'(cmd_out), 0);
        tick();
        chk("t1_op1_cmd",  32'(cmd_out), 1);
        chk("t1_op1_data", data_out, 5);
        chk("t1_op1_tag",  32'(tag_out), 0);
        chk("t1_outstand", 32'(outstanding), 1);
        tick();
        chk("t1_op2_cmd",  32'(cmd_out), 0);
        chk("t1_op2_data", data_out, 7);
        chk("t1_op2_tag",  32'(tag_out), 0);
        tick();
        chk("t1_idle_data", data_out, 0);
        respond(2'd1, 32'd12, 2'd0);
        chk("t1_rsp_valid", 32'(rsp_valid), 1);
        chk("t1_rsp_code",  32'(rsp_code), 1);
        chk("t1_rsp_data",  rsp_data, 12);
        chk("t1_rsp_id",    32'(rsp_id), 3);
        chk("t1_rsp_tag",   32'(rsp_tag), 0);
        pop();
        chk("t1_pop_valid", 32'(rsp_valid), 0);
        chk("t1_pop_outst", 32'(outstanding), 0);
        chk("t1_pop_busy",  32'(busy), 0);

        // 2: five ops, four tags, fifth waits for a freed tag
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(4'd1, 32'h100 + 32'(i), 32'(i), 4'(i));
        end
        repeat (10) tick_rec();
        chk("t2_n_issued", 32'(n_iss), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_tag%0d", k),  32'(iss_tag[k]), 32'(k));
            chk($sformatf("t2_data%0d", k), iss_data[k], 32'h100 + 32'(k));
        end
        chk("t2_outstand", 32'(outstanding), 4);
        chk("t2_busy",     32'(busy), 1);
        respond(2'd1, 32'h55, 2'd2);
        chk("t2_rsp_tag",  32'(rsp_tag), 2);
        chk("t2_rsp_id",   32'(rsp_id), 2);
        chk("t2_rsp_data", rsp_data, 32'h55);
        pop();
        chk("t2_pop_cmd",   32'(cmd_out), 0);
        chk("t2_pop_outst", 32'(outstanding), 3);
        tick();
        chk("t2_re_cmd",   32'(cmd_out), 1);
        chk("t2_re_tag",   32'(tag_out), 2);
        chk("t2_re_data",  data_out, 32'h104);
        chk("t2_re_outst", 32'(outstanding), 4);

        // 3/4: out-of-order responses held in arrival order, FIFO fills
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(4'd1, 32'(i), 32'h200 + 32'(i), 4'(4 + i));
        end
        repeat (10) tick_rec();
        chk("t3_n_issued", 32'(n_iss), 4);
        for (int k = 0; k < 4; k++) begin
            respond((order[k] == 2'd0) ? 2'd2 : 2'd1, 32'hA0 + 32'(order[k]), order[k]);
        end
        chk("t3_rsp_valid", 32'(rsp_valid), 1);
        chk("t3_outstand",  32'(outstanding), 4);
        for (int i = 0; i < 4; i++) begin
            push(4'd2, 32'h300 + 32'(i), 32'd1, 4'd9);
        end
        chk("t4_req_ready", 32'(req_ready), 0);
        chk("t4_no_issue",  32'(cmd_out), 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_valid%0d", k), 32'(rsp_valid), 1);
            chk($sformatf("t3_tag%0d", k),   32'(rsp_tag), 32'(order[k]));
            chk($sformatf("t3_id%0d", k),    32'(rsp_id), 32'(order[k]) + 4);
            chk($sformatf("t3_data%0d", k),  rsp_data, 32'hA0 + 32'(order[k]));
            chk($sformatf("t3_code%0d", k),  32'(rsp_code), (order[k] == 2'd0) ? 2 : 1);
            pop();
        end
        chk("t3_empty", 32'(rsp_valid), 0);

        // 5: spurious responses and timeout
        do_reset();
        respond(2'd1, 32'd9, 2'd1);
        chk("t5_sp_err",   32'(err_spurious), 1);
        chk("t5_sp_valid", 32'(rsp_valid), 0);
        do_reset();
        chk("t5_sp_clr",   32'(err_spurious), 0);
        respond(2'd3, 32'd0, 2'd0);
        chk("t5_sp_ill",   32'(err_spurious), 1);
        do_reset();
        push(4'd5, 32'd1, 32'd3, 4'd1);
        tick();
        chk("t5_to_issue", 32'(cmd_out), 5);
        repeat (15) tick();
        chk("t5_to_before", 32'(err_timeout), 0);
        tick();
        chk("t5_to_after",  32'(err_timeout), 1);
        chk("t5_to_outst",  32'(outstanding), 1);

        // 6: reset in the OP2 cycle
        do_reset();
        push(4'd6, 32'h11, 32'h22, 4'd5);
        tick();
        tick();
        chk("t6_op2_data", data_out, 32'h22);
        reset = 1'b1;
        #1;
        chk("t6_rst_cmd",   32'(cmd_out), 0);
        chk("t6_rst_data",  data_out, 0);
        chk("t6_rst_tag",   32'(tag_out), 0);
        chk("t6_rst_busy",  32'(busy), 0);
        chk("t6_rst_outst", 32'(outstanding), 0);
        tick();
        reset = 1'b0;
        tick();
        respond(2'd1, 32'h33, 2'd0);
        chk("t6_sp_err",   32'(err_spurious), 1);
        chk("t6_sp_valid", 32'(rsp_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
